// File: rtl/axi_lite_reg_bridge_if.sv
// Bus bundle between an AXI-Lite buffer stage and the register bridge, plus the
// single-outstanding register-access port the bridge drives towards a register file.
interface axi_lite_reg_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      aw_valid;
  logic                      aw_ready;
  logic [ADDR_WIDTH-1:0]     aw_addr;
  logic [2:0]                aw_prot;
  logic                      w_valid;
  logic                      w_ready;
  logic [DATA_WIDTH-1:0]     w_data;
  logic [DATA_WIDTH/8-1:0]   w_strb;
  logic                      b_valid;
  logic                      b_ready;
  logic [1:0]                b_resp;
  logic                      ar_valid;
  logic                      ar_ready;
  logic [ADDR_WIDTH-1:0]     ar_addr;
  logic [2:0]                ar_prot;
  logic                      r_valid;
  logic                      r_ready;
  logic [DATA_WIDTH-1:0]     r_data;
  logic [1:0]                r_resp;
  logic                      reg_req;
  logic                      reg_we;
  logic [ADDR_WIDTH-1:0]     reg_addr;
  logic [DATA_WIDTH-1:0]     reg_wdata;
  logic [DATA_WIDTH/8-1:0]   reg_wstrb;
  logic                      reg_ready;
  logic [DATA_WIDTH-1:0]     reg_rdata;
  logic                      reg_err;

  modport slave (
    input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready, reg_ready, reg_rdata, reg_err,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp,
           reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb
  );

  modport master (
    output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready, reg_ready, reg_rdata, reg_err,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp,
           reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb
  );
endinterface

// File: rtl/axi_lite_reg_bridge.sv
// AXI-Lite slave endpoint: holds AW/W/AR beats and replays them one at a time on a
// request/ready register port, arbitrating reads and writes round-robin.
//
// state  | meaning
// IDLE   | waiting for a complete write (AW+W held) or a held read
// ACCESS | reg_req high, waiting for reg_ready
// RESP   | b_valid or r_valid high, waiting for the AXI response handshake
module axi_lite_reg_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  axi_lite_reg_bridge_if.slave bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state;
  logic                    aw_full, w_full, ar_full;
  logic                    last_was_write, sel_write;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, ar_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_WIDTH-1:0]   w_strb_q;

  logic                    b_valid_q, r_valid_q;
  logic [1:0]              b_resp_q, r_resp_q;
  logic [DATA_WIDTH-1:0]   r_data_q;
  logic                    reg_req_q, reg_we_q;
  logic [ADDR_WIDTH-1:0]   reg_addr_q;
  logic [DATA_WIDTH-1:0]   reg_wdata_q;
  logic [STRB_WIDTH-1:0]   reg_wstrb_q;

  logic write_pending, read_pending, pick_write;
  logic unused_prot;

  assign write_pending = aw_full && w_full;
  assign read_pending  = ar_full;
  // On a tie, serve whichever kind did not go last.
  assign pick_write    = write_pending && (!read_pending || !last_was_write);
  assign unused_prot   = ^{bus.aw_prot, bus.ar_prot};

  assign bus.aw_ready  = !rst && !aw_full;
  assign bus.w_ready   = !rst && !w_full;
  assign bus.ar_ready  = !rst && !ar_full;
  assign bus.b_valid   = b_valid_q;
  assign bus.b_resp    = b_resp_q;
  assign bus.r_valid   = r_valid_q;
  assign bus.r_resp    = r_resp_q;
  assign bus.r_data    = r_data_q;
  assign bus.reg_req   = reg_req_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_wstrb = reg_wstrb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      aw_full        <= 1'b0;
      w_full         <= 1'b0;
      ar_full        <= 1'b0;
      last_was_write <= 1'b0;
      sel_write      <= 1'b0;
      aw_addr_q      <= '0;
      ar_addr_q      <= '0;
      w_data_q       <= '0;
      w_strb_q       <= '0;
      b_valid_q      <= 1'b0;
      r_valid_q      <= 1'b0;
      b_resp_q       <= 2'b00;
      r_resp_q       <= 2'b00;
      r_data_q       <= '0;
      reg_req_q      <= 1'b0;
      reg_we_q       <= 1'b0;
      reg_addr_q     <= '0;
      reg_wdata_q    <= '0;
      reg_wstrb_q    <= '0;
    end else begin
      if (bus.aw_valid && !aw_full) begin
        aw_full   <= 1'b1;
        aw_addr_q <= bus.aw_addr;
      end
      if (bus.w_valid && !w_full) begin
        w_full   <= 1'b1;
        w_data_q <= bus.w_data;
        w_strb_q <= bus.w_strb;
      end
      if (bus.ar_valid && !ar_full) begin
        ar_full   <= 1'b1;
        ar_addr_q <= bus.ar_addr;
      end

      case (state)
        IDLE: begin
          if (write_pending || read_pending) begin
            sel_write      <= pick_write;
            last_was_write <= pick_write;
            reg_req_q      <= 1'b1;
            reg_we_q       <= pick_write;
            reg_addr_q     <= pick_write ? aw_addr_q : ar_addr_q;
            reg_wdata_q    <= pick_write ? w_data_q : '0;
            reg_wstrb_q    <= pick_write ? w_strb_q : '0;
            state          <= ACCESS;
          end
        end
        ACCESS: begin
          if (bus.reg_ready) begin
            reg_req_q <= 1'b0;
            state     <= RESP;
            if (sel_write) begin
              b_valid_q <= 1'b1;
              b_resp_q  <= bus.reg_err ? 2'b10 : 2'b00;
            end else begin
              r_valid_q <= 1'b1;
              r_resp_q  <= bus.reg_err ? 2'b10 : 2'b00;
              r_data_q  <= bus.reg_rdata;
            end
          end
        end
        RESP: begin
          // Holding flags are released only here, so a new AW/W waits for the B beat.
          if (b_valid_q && bus.b_ready) begin
            b_valid_q <= 1'b0;
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            state     <= IDLE;
          end else if (r_valid_q && bus.r_ready) begin
            r_valid_q <= 1'b0;
            ar_full   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
